// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage owning the PC and IF/ID register; HALT_ON_ZERO_EN adds halt-on-zero-word
module fetch_unit #(
   parameter int ADDRESS_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     stall,
   input  logic                     redirect,
   input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
   output logic [ADDRESS_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0]    rom_data,
   output logic [DATA_WIDTH-1:0]    instr,
   output logic [ADDRESS_WIDTH-1:0] instr_pc,
   output logic                     instr_valid,
   output logic                     halted
);
`ifdef HALT_ON_ZERO_EN
   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
`else
   typedef enum logic {BOOT, RUN} state_t;
`endif
   state_t state, state_d;
   logic [ADDRESS_WIDTH-1:0] pc, pc_d, instr_pc_d, target;
   logic [DATA_WIDTH-1:0] instr_d;
   logic valid_d;
   assign rom_addr = pc;
   assign target = redirect_pc & ~ADDRESS_WIDTH'(3);
`ifdef HALT_ON_ZERO_EN
   logic halted_d;
   // halt flag register, cleared only by reset or a redirect out of HALT
   always_ff @(posedge clk)
      halted <= !rst_n ? 1'b0 : halted_d;
`else
   assign halted = 1'b0;
`endif
   // state, PC and IF/ID register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= BOOT;
         pc <= RESET_PC;
         instr <= '0;
         instr_pc <= '0;
         instr_valid <= 1'b0;
      end else begin
         state <= state_d;
         pc <= pc_d;
         instr <= instr_d;
         instr_pc <= instr_pc_d;
         instr_valid <= valid_d;
      end
   end
   // next-state: redirect beats stall beats normal capture
   always_comb begin
      state_d = state;
      pc_d = pc;
      instr_d = instr;
      instr_pc_d = instr_pc;
      valid_d = instr_valid;
`ifdef HALT_ON_ZERO_EN
      halted_d = halted;
`endif
      case (state)
         BOOT: begin
            state_d = RUN;
            if (redirect) pc_d = target;
         end
         RUN: begin
            if (redirect) begin
               pc_d = target;
               instr_d = '0;
               valid_d = 1'b0;
            end else if (!stall) begin
`ifdef HALT_ON_ZERO_EN
               if (rom_data == '0) begin
                  valid_d = 1'b0;
                  halted_d = 1'b1;
                  state_d = HALT;
               end else begin
                  instr_d = rom_data;
                  instr_pc_d = pc;
                  valid_d = 1'b1;
                  pc_d = pc + ADDRESS_WIDTH'(4);
               end
`else
               instr_d = rom_data;
               instr_pc_d = pc;
               valid_d = 1'b1;
               pc_d = pc + ADDRESS_WIDTH'(4);
`endif
            end
         end
`ifdef HALT_ON_ZERO_EN
         HALT: begin
            valid_d = 1'b0;
            if (redirect) begin
               pc_d = target;
               halted_d = 1'b0;
               state_d = RUN;
            end
         end
`endif
         default: state_d = BOOT;
      endcase
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus random stimulus against a behavioural fetch model
module tb_fetch_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0, stall = 1'b0, redirect = 1'b0;
   logic [11:0] redirect_pc = '0, rom_addr, instr_pc;
   logic [31:0] rom_data, instr;
   logic instr_valid, halted;
   logic [31:0] mem [0:1023];
   int errors = 0, checks = 0;
   int m_pc, m_instr, m_ipc;
   bit m_valid, m_halted, m_boot;

   fetch_unit #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32), .RESET_PC(12'h000)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .rom_addr(rom_addr), .rom_data(rom_data),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .halted(halted)
   );

   assign rom_data = mem[rom_addr[11:2]];
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit s, input bit d, input int t);
      int w;
      if (!r) begin
         m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_halted = 0; m_boot = 1;
      end else if (m_boot) begin
         m_boot = 0;
         if (d) m_pc = t & ~3;
      end else if (m_halted) begin
         if (d) begin m_pc = t & ~3; m_halted = 0; end
      end else if (d) begin
         m_pc = t & ~3; m_instr = 0; m_valid = 0;
      end else if (!s) begin
         w = mem[m_pc / 4];
`ifdef HALT_ON_ZERO_EN
         if (w == 0) begin m_valid = 0; m_halted = 1; end
         else begin m_instr = w; m_ipc = m_pc; m_valid = 1; m_pc = (m_pc + 4) % 4096; end
`else
         m_instr = w; m_ipc = m_pc; m_valid = 1; m_pc = (m_pc + 4) % 4096;
`endif
      end
   endtask

   task automatic cycle(input bit r, input bit s, input bit d, input int t);
      rst_n = r; stall = s; redirect = d; redirect_pc = 12'(t);
      model_step(r, s, d, t);
      @(posedge clk);
      #1;
      check("rom_addr", 32'(rom_addr), 32'(m_pc));
      check("instr", instr, 32'(m_instr));
      check("instr_pc", 32'(instr_pc), 32'(m_ipc));
      check("instr_valid", 32'(instr_valid), 32'(m_valid));
      check("halted", 32'(halted), 32'(m_halted));
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom() | 32'h1;
      mem[0] = 32'h11111111; mem[1] = 32'h22222222;
      mem[2] = 32'h33333333; mem[3] = 32'h44444444;
      m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_halted = 0; m_boot = 1;
      cycle(0, 0, 0, 0);
      cycle(0, 1, 1, 12'h123);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
      cycle(1, 1, 1, 12'h00B);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 1, 12'hFFE);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      mem[2] = 32'h0;
      cycle(1, 0, 1, 0);
      for (int i = 0; i < 8; i++) cycle(1, i == 4, 0, 0);
      cycle(1, 0, 1, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      mem[2] = 32'h33333333;
      cycle(0, 1, 1, 12'h040);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 64; i++) if ($urandom_range(0, 7) == 0) mem[i] = 32'h0;
      for (int i = 0; i < 1500; i++)
         cycle($urandom_range(0, 59) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 255)));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
